sctrl_capture_sequencer: RTL and testbench

// - Autonomous sequencer for the sensor controller (sctrl): enable, wait frame IRQ, drain result words, clear.
// - Drives sctrl_en/sctrl_clear/sctrl_addr directly; results leave on a valid/ready stream toward the DMA.
// - Sits beside the sctrl AXI slave wrapper; top-level mux selects one sctrl driver (seq_busy=1 selects this).

---
 rtl/sctrl_pkg.sv | 19 +
 rtl/sctrl_capture_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_sctrl_capture_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sctrl_pkg.sv
// Shared definitions for the sensor controller (sctrl) blocks.
//   SCTRL_DATA_W : width of one sensor result word
//   SCTRL_ADDR_W : default word-address width into the sensor result memory
//   seq_state_e  : capture sequencer state encoding
package sctrl_pkg;

  localparam int unsigned SCTRL_DATA_W = 32;
  localparam int unsigned SCTRL_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENABLE   = 3'd1,
    WAIT_IRQ = 3'd2,
    DRAIN    = 3'd3,
    CLEAR    = 3'd4,
    WAIT_LOW = 3'd5
  } seq_state_e;

endpackage

// File: rtl/sctrl_capture_sequencer.sv
// Autonomous capture sequencer for the sensor controller: enables the sensor,
// waits for the frame-done interrupt, drains cfg_len result words onto a
// valid/ready stream, pulses clear and waits for the interrupt to drop.
//
// Ports
//   CLK, RSTn         clock; asynchronous active-low reset
//   start, abort      run request (IDLE only) / synchronous abort (non-IDLE)
//   cfg_len           words to drain, latched on an accepted start (0 = none)
//   sctrl_en          sensor enable level
//   sctrl_clear       sensor clear, one-cycle pulse
//   sctrl_addr        read address into sensor result memory (wraps)
//   sctrl_out         read data for the current sctrl_addr (combinational)
//   sctrl_interrupt   frame-done level from the sensor
//   out_data/valid/last/ready  result stream toward the DMA
//   seq_busy          sequencer owns the sctrl interface (state != IDLE)
//   seq_done          one-cycle pulse on return to IDLE
//   seq_err           last run was aborted or timed out
//
// Build option
//   SCTRL_SEQ_TIMEOUT_EN : when defined, WAIT_IRQ gives up after TIMEOUT_CYC
//                          cycles and takes the abort path.
module sctrl_capture_sequencer
  import sctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = SCTRL_ADDR_W,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W:0]         cfg_len,
  output logic                    sctrl_en,
  output logic                    sctrl_clear,
  output logic [ADDR_W-1:0]       sctrl_addr,
  input  logic [SCTRL_DATA_W-1:0] sctrl_out,
  input  logic                    sctrl_interrupt,
  output logic [SCTRL_DATA_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    seq_busy,
  output logic                    seq_done,
  output logic                    seq_err
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  // Elaboration-time sanity check on the timeout length.
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("sctrl_capture_sequencer: TIMEOUT_CYC must be nonzero");
  end

  seq_state_e              state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    en_q, en_d;
  logic                    clear_q, clear_d;
  logic [SCTRL_DATA_W-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    timeout_c;

`ifdef SCTRL_SEQ_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] timer_q, timer_d;

  // Timer counts WAIT_IRQ cycles without an interrupt; zero everywhere else.
  always_comb begin
    timer_d   = '0;
    timeout_c = 1'b0;
    if (state_q == WAIT_IRQ && !sctrl_interrupt) begin
      timer_d   = timer_q + TMR_W'(1);
      timeout_c = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state, counters and the one-entry output register.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    en_d    = en_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ENABLE;
          len_d   = cfg_len;
          err_d   = 1'b0;
        end
      end
      ENABLE: begin
        en_d    = 1'b1;
        state_d = WAIT_IRQ;
      end
      WAIT_IRQ: begin
        if (sctrl_interrupt) begin
          en_d    = 1'b0;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = (len_q != '0) ? DRAIN : CLEAR;
        end
      end
      DRAIN: begin
        if (valid_q && last_q && out_ready) begin
          // Final word accepted; cnt == len here so nothing new is loaded.
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = CLEAR;
        end else if ((!valid_q || out_ready) && (cnt_q < len_q)) begin
          data_d  = sctrl_out;
          valid_d = 1'b1;
          last_d  = ((cnt_q + LEN_W'(1)) == len_q);
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + LEN_W'(1);
        end else if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      CLEAR: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!sctrl_interrupt) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort and timeout override everything; any pending word is dropped.
    if (state_q != IDLE && (abort || timeout_c)) begin
      state_d = CLEAR;
      en_d    = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  // Status/strobe outputs registered from the next state so they align with it.
  always_comb begin
    busy_d  = (state_d != IDLE);
    clear_d = (state_d == CLEAR);
    done_d  = (state_q == WAIT_LOW) && (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      clear_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      clear_q <= clear_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sctrl_en    = en_q;
  assign sctrl_clear = clear_q;
  assign sctrl_addr  = addr_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign seq_busy    = busy_q;
  assign seq_done    = done_q;
  assign seq_err     = err_q;

endmodule

// File: tb/tb_sctrl_capture_sequencer.sv
// Self-checking bench for sctrl_capture_sequencer. A sensor memory model
// supplies sctrl_out; each run is checked against the expected word stream
// (word i = mem[i mod 2^ADDR_W]), the protocol latencies and the status flags.
module tb_sctrl_capture_sequencer;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned MEM_N  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              sctrl_en;
  logic              sctrl_clear;
  logic [ADDR_W-1:0] sctrl_addr;
  logic [31:0]       sctrl_out;
  logic              sctrl_interrupt = 1'b0;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic              seq_busy;
  logic              seq_done;
  logic              seq_err;

  logic [31:0] mem [MEM_N];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  assign sctrl_out = mem[sctrl_addr];

  sctrl_capture_sequencer #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (20)
  ) dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .start           (start),
    .abort           (abort),
    .cfg_len         (cfg_len),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_addr      (sctrl_addr),
    .sctrl_out       (sctrl_out),
    .sctrl_interrupt (sctrl_interrupt),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_last        (out_last),
    .out_ready       (out_ready),
    .seq_busy        (seq_busy),
    .seq_done        (seq_done),
    .seq_err         (seq_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_en"},    64'(sctrl_en),    64'd0);
    check({pfx, "_clear"}, 64'(sctrl_clear), 64'd0);
    check({pfx, "_addr"},  64'(sctrl_addr),  64'd0);
    check({pfx, "_data"},  64'(out_data),    64'd0);
    check({pfx, "_valid"}, 64'(out_valid),   64'd0);
    check({pfx, "_last"},  64'(out_last),    64'd0);
    check({pfx, "_busy"},  64'(seq_busy),    64'd0);
    check({pfx, "_done"},  64'(seq_done),    64'd0);
    check({pfx, "_err"},   64'(seq_err),     64'd0);
  endtask

  // One full run: start, IRQ after irq_dly cycles, drain with random ready,
  // optional abort once abort_at words were accepted (abort_at < 0: none).
  task automatic run_txn(input int len, input int irq_dly, input int rdy_pct,
                         input int abort_at, input bit start_with_abort);
    int  n;
    int  cyc;
    int  first;
    int  budget;
    bit  held;
    bit  aborted;
    bit  abort_pend;
    bit  saw_clear;
    logic [31:0] held_data;

    start   = 1'b1;
    abort   = start_with_abort;
    cfg_len = LEN_W'(len);
    tick();
    start   = 1'b0;
    abort   = 1'b0;
    cfg_len = LEN_W'($urandom);
    check("start_busy", 64'(seq_busy), 64'd1);
    check("start_en1",  64'(sctrl_en), 64'd0);
    check("start_err",  64'(seq_err),  64'd0);
    tick();
    check("start_en2",  64'(sctrl_en), 64'd1);
    repeat (irq_dly) tick();
    check("irq_en_hold", 64'(sctrl_en), 64'd1);
    sctrl_interrupt = 1'b1;

    n = 0; cyc = 0; first = -1; held = 1'b0; aborted = 1'b0;
    abort_pend = 1'b0; saw_clear = 1'b0; held_data = '0;
    budget = len * 30 + 40;
    while (!saw_clear && cyc < budget) begin
      tick();
      cyc++;
      abort = 1'b0;
      if (cyc == 1) check("irq_en_drop", 64'(sctrl_en), 64'd0);
      if (abort_pend) begin
        check("abort_valid", 64'(out_valid),   64'd0);
        check("abort_en",    64'(sctrl_en),    64'd0);
        check("abort_clear", 64'(sctrl_clear), 64'd1);
        abort_pend = 1'b0;
      end
      if (sctrl_clear) saw_clear = 1'b1;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (held) check("hold_data", 64'(out_data), 64'(held_data));
        check("word_data", 64'(out_data), 64'(mem[ADDR_W'(n)]));
        check("word_last", 64'(out_last), 64'(n == len - 1));
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      if (!saw_clear && abort_at >= 0 && !aborted && n == abort_at) begin
        abort      = 1'b1;
        aborted    = 1'b1;
        abort_pend = 1'b1;
        out_ready  = 1'b0;
      end
      held      = out_valid && !out_ready && !abort;
      held_data = out_data;
      if (out_valid && out_ready && !saw_clear) n++;
    end
    abort = 1'b0;

    check("clear_seen", 64'(saw_clear), 64'd1);
    check("words",      64'(n), 64'(aborted ? abort_at : len));
    if (len > 0) check("first_lat", 64'(first), 64'd2);
    else         check("no_words",  64'(first), 64'(-1));
    check("clear_valid", 64'(out_valid), 64'd0);
    check("run_err",     64'(seq_err),   64'(aborted));

    // start during CLEAR must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("clear_pulse", 64'(sctrl_clear), 64'd0);
    check("wl_busy",     64'(seq_busy),    64'd1);
    check("wl_err",      64'(seq_err),     64'(aborted));
    repeat ($urandom_range(0, 4)) tick();
    check("wl_wait", 64'(seq_busy), 64'd1);
    sctrl_interrupt = 1'b0;
    tick();
    check("done_pulse", 64'(seq_done), 64'd1);
    check("done_busy",  64'(seq_busy), 64'd0);
    check("done_en",    64'(sctrl_en), 64'd0);
    tick();
    check("done_drop",  64'(seq_done), 64'd0);
    check("idle_busy",  64'(seq_busy), 64'd0);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = $urandom;

    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    RSTn = 1'b1;
    tick();

    // abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", 64'(seq_busy), 64'd0);
    check("idle_abort_err",  64'(seq_err),  64'd0);

    run_txn(4, 10, 100, -1, 1'b0);
    run_txn(3, 5, 50, -1, 1'b0);
    run_txn(0, 3, 100, -1, 1'b0);
    run_txn(6, 4, 100, 1, 1'b0);
    run_txn(5, 2, 70, -1, 1'b0);
    run_txn(4, 1, 60, -1, 1'b1);

    for (int t = 0; t < 10; t++) begin
      int len;
      int ab;
      len = $urandom_range(0, 20);
      ab  = -1;
      if (len >= 2 && $urandom_range(3) == 0) ab = $urandom_range(1, len - 1);
      run_txn(len, $urandom_range(0, 15), $urandom_range(20, 100), ab, 1'b0);
    end

    // address wrap past the end of the result memory
    run_txn(MEM_N + 4, 1, 100, -1, 1'b0);

`ifndef SCTRL_SEQ_TIMEOUT_EN
    // no timeout: a long IRQ wait is fine
    run_txn(2, 40, 100, -1, 1'b0);
`endif

`ifdef SCTRL_SEQ_TIMEOUT_EN
    begin
      int en_cyc;
      start   = 1'b1;
      cfg_len = LEN_W'(5);
      tick();
      start = 1'b0;
      tick();
      en_cyc = 0;
      while (sctrl_en && en_cyc < 100) begin
        en_cyc++;
        tick();
      end
      check("to_en_cycles", 64'(en_cyc),      64'd20);
      check("to_clear",     64'(sctrl_clear), 64'd1);
      check("to_err",       64'(seq_err),     64'd1);
      tick();
      check("to_clear_drop", 64'(sctrl_clear), 64'd0);
      tick();
      check("to_done", 64'(seq_done), 64'd1);
      check("to_idle", 64'(seq_busy), 64'd0);
      tick();
    end
`endif

    // reset mid-DRAIN with a held word
    begin
      int w;
      out_ready = 1'b0;
      start     = 1'b1;
      cfg_len   = LEN_W'(8);
      tick();
      start = 1'b0;
      repeat (3) tick();
      sctrl_interrupt = 1'b1;
      w = 0;
      while (!out_valid && w < 10) begin
        tick();
        w++;
      end
      check("rst_pre_valid", 64'(out_valid), 64'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rst_busy_start", 64'(seq_busy),  64'd1);
      check("rst_hold_data",  64'(out_data),  64'(mem[0]));
      #2;
      RSTn = 1'b0;
      #1;
      check_all_zero("midrst");
      sctrl_interrupt = 1'b0;
      tick();
      check("rst_no_clear", 64'(sctrl_clear), 64'd0);
      RSTn = 1'b1;
      tick();
      check("rst_idle", 64'(seq_busy), 64'd0);
    end

    run_txn(3, 2, 100, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
